// File: rtl/frame_aligner_pkg.sv
// Shared types and sizing helpers for the AXI4-Stream frame aligner.
// Counter widths never drop below one bit so 1x1 frames stay legal.
package frame_aligner_pkg;

  typedef enum logic [1:0] {
    WAIT_SOF,
    ACTIVE,
    PAD,
    RELEASE
  } state_t;

  localparam int STAT_W = 16;

  function automatic int x_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  function automatic int y_w(input int height);
    return (height > 1) ? $clog2(height) : 1;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// One-deep AXI4-Stream register slice carrying data, user and last.
// Loads whenever the slot is empty or being drained in the same cycle.
module axis_out_reg #(
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] data,
  input  logic          user,
  input  logic          last,
  input  logic          valid,
  output logic          ready,
  output logic [DW-1:0] q_data,
  output logic          q_user,
  output logic          q_last,
  output logic          q_valid,
  input  logic          q_ready
);

  assign ready = !q_valid || q_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_valid <= 1'b0;
      q_data  <= '0;
      q_user  <= 1'b0;
      q_last  <= 1'b0;
    end else if (ready) begin
      q_valid <= valid;
      if (valid) begin
        q_data <= data;
        q_user <= user;
        q_last <= last;
      end
    end
  end

endmodule

// File: rtl/axis_frame_aligner.sv
// Regenerates tuser/tlast on exact WIDTH x HEIGHT frames, padding and dropping.
// Define AXIS_FRAME_ALIGNER_STATS_EN to add saturating frame/pad/drop counters.
module axis_frame_aligner
  import frame_aligner_pkg::*;
#(
  parameter int                    WIDTH      = 128,
  parameter int                    HEIGHT     = 100,
  parameter int                    DATA_WIDTH = 24,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  frame_err
`ifdef AXIS_FRAME_ALIGNER_STATS_EN
  ,
  output logic [STAT_W-1:0]     stat_frames,
  output logic [STAT_W-1:0]     stat_padded,
  output logic [STAT_W-1:0]     stat_dropped
`endif
);

  localparam int XW = x_w(WIDTH);
  localparam int YW = y_w(HEIGHT);
  localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);

  state_t state, state_nx;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [DATA_WIDTH-1:0] hold;
  logic [DATA_WIDTH-1:0] push_data;
  logic push, push_user, advance;
  logic capture, drop, dropping;
  logic slot_free, open, s_hs, eof;
  logic unused_tlast;

  assign unused_tlast  = s_axis_tlast;
  assign open          = (state == WAIT_SOF) || (state == ACTIVE);
  assign s_axis_tready = open && slot_free && !rst;
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  assign eof           = (x == X_MAX) && (y == Y_MAX);

  always_comb begin
    state_nx  = state;
    push      = 1'b0;
    push_user = 1'b0;
    push_data = s_axis_tdata;
    advance   = 1'b0;
    capture   = 1'b0;
    drop      = 1'b0;
    unique case (state)
      WAIT_SOF: begin
        if (s_hs && s_axis_tuser) begin
          push      = 1'b1;
          push_user = 1'b1;
          advance   = 1'b1;
          if (!eof) state_nx = ACTIVE;
        end else if (s_hs) begin
          drop = 1'b1;
        end
      end
      ACTIVE: begin
        // an early SOF, even on the final slot, pads the rest of the frame
        if (s_hs && s_axis_tuser) begin
          capture  = 1'b1;
          state_nx = PAD;
        end else if (s_hs) begin
          push    = 1'b1;
          advance = 1'b1;
          if (eof) state_nx = WAIT_SOF;
        end
      end
      PAD: begin
        push_data = PAD_VALUE;
        if (slot_free) begin
          push    = 1'b1;
          advance = 1'b1;
          if (eof) state_nx = RELEASE;
        end
      end
      RELEASE: begin
        push_data = hold;
        push_user = 1'b1;
        if (slot_free) begin
          push     = 1'b1;
          advance  = 1'b1;
          state_nx = eof ? WAIT_SOF : ACTIVE;
        end
      end
      default: state_nx = WAIT_SOF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT_SOF;
      x         <= '0;
      y         <= '0;
      hold      <= '0;
      dropping  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      frame_err <= capture || (drop && !dropping);
      if (capture) hold <= s_axis_tdata;
      if (drop) dropping <= 1'b1;
      else if (push && push_user) dropping <= 1'b0;
      if (advance) begin
        if (x == X_MAX) begin
          x <= '0;
          y <= (y == Y_MAX) ? '0 : y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end

  axis_out_reg #(
    .DW(DATA_WIDTH)
  ) u_out (
    .clk    (clk),
    .rst    (rst),
    .data   (push_data),
    .user   (push_user),
    .last   (eof),
    .valid  (push),
    .ready  (slot_free),
    .q_data (m_axis_tdata),
    .q_user (m_axis_tuser),
    .q_last (m_axis_tlast),
    .q_valid(m_axis_tvalid),
    .q_ready(m_axis_tready)
  );

`ifdef AXIS_FRAME_ALIGNER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_frames  <= '0;
      stat_padded  <= '0;
      stat_dropped <= '0;
    end else begin
      if (push && eof && stat_frames != '1)
        stat_frames <= stat_frames + 1'b1;
      if (capture && stat_padded != '1)
        stat_padded <= stat_padded + 1'b1;
      if (drop && stat_dropped != '1)
        stat_dropped <= stat_dropped + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_frame_aligner.sv
// Bench for axis_frame_aligner: cycle table on a 4x2 build plus
// randomized 128x100 traffic scored against a beat-list frame model.
module tb_axis_frame_aligner;

  localparam int W  = 128;
  localparam int H  = 100;
  localparam int N  = W * H;
  localparam int DW = 24;
  localparam logic [DW-1:0] PADV = '0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [DW-1:0] s_data, m_data;
  logic s_valid, s_user, s_last, s_ready;
  logic m_valid, m_user, m_last, m_ready, err;

  logic [DW-1:0] t_sdata, t_mdata;
  logic t_svalid, t_suser, t_slast, t_sready;
  logic t_mvalid, t_muser, t_mlast, t_mready, t_err;

`ifdef AXIS_FRAME_ALIGNER_STATS_EN
  logic [15:0] st_frames, st_padded, st_dropped;
  logic [15:0] tst_frames, tst_padded, tst_dropped;
`endif

  axis_frame_aligner dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_data), .s_axis_tvalid(s_valid),
    .s_axis_tuser(s_user), .s_axis_tlast(s_last),
    .s_axis_tready(s_ready),
    .m_axis_tdata(m_data), .m_axis_tvalid(m_valid),
    .m_axis_tuser(m_user), .m_axis_tlast(m_last),
    .m_axis_tready(m_ready), .frame_err(err)
`ifdef AXIS_FRAME_ALIGNER_STATS_EN
    , .stat_frames(st_frames), .stat_padded(st_padded),
    .stat_dropped(st_dropped)
`endif
  );

  axis_frame_aligner #(.WIDTH(4), .HEIGHT(2)) tiny (
    .clk(clk), .rst(rst),
    .s_axis_tdata(t_sdata), .s_axis_tvalid(t_svalid),
    .s_axis_tuser(t_suser), .s_axis_tlast(t_slast),
    .s_axis_tready(t_sready),
    .m_axis_tdata(t_mdata), .m_axis_tvalid(t_mvalid),
    .m_axis_tuser(t_muser), .m_axis_tlast(t_mlast),
    .m_axis_tready(t_mready), .frame_err(t_err)
`ifdef AXIS_FRAME_ALIGNER_STATS_EN
    , .stat_frames(tst_frames), .stat_padded(tst_padded),
    .stat_dropped(tst_dropped)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model for the 128x100 instance
  typedef struct packed {
    logic [DW-1:0] d;
    logic u;
    logic l;
  } beat_t;

  beat_t exp_q[$];
  int pos = 0;
  bit in_frame = 0, dropping = 0, err_exp = 0;
  bit fwd_prev = 0, stall_prev = 0, rst_prev = 0;
  beat_t stall_beat;
  int err_pulses = 0;
  int mode = 0;

  task automatic model_in(input logic [DW-1:0] d, input logic u);
    if (!in_frame) begin
      if (u) begin
        exp_q.push_back(beat_t'({d, 1'b1, 1'b0}));
        fwd_prev = 1; pos = 1; in_frame = 1; dropping = 0;
      end else begin
        if (!dropping) err_exp = 1;
        dropping = 1;
      end
    end else if (u) begin
      for (int k = pos; k < N; k++)
        exp_q.push_back(beat_t'({PADV, 1'b0, k == N - 1}));
      exp_q.push_back(beat_t'({d, 1'b1, 1'b0}));
      pos = 1; err_exp = 1;
    end else begin
      exp_q.push_back(beat_t'({d, 1'b0, pos == N - 1}));
      fwd_prev = 1;
      if (pos == N - 1) begin in_frame = 0; pos = 0; end
      else pos++;
    end
  endtask

  always @(negedge clk) begin
    case (mode)
      0: m_ready = 1'b1;
      1: m_ready = !m_ready;
      default: m_ready = ($urandom_range(3) != 0);
    endcase
  end

  always @(negedge clk) begin
    beat_t b;
    #4;
    if (rst_prev) begin
      chk("rst_ctl", 32'({m_valid, m_user, m_last, err}), 32'd0);
      chk("rst_data", 32'(m_data), 32'd0);
    end else begin
      if (stall_prev)
        chk("stall_hold", 32'({m_valid, m_data, m_user, m_last}),
            32'({1'b1, stall_beat}));
      if (fwd_prev) chk("latency", 32'(m_valid), 32'd1);
      chk("frame_err", 32'(err), 32'(err_exp));
    end
    if (err) err_pulses++;
    if (rst) chk("rst_sready", 32'(s_ready), 32'd0);
    chk("sready_rule", 32'(s_ready && m_valid && !m_ready), 32'd0);
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        chk("extra_beat", 32'(m_data), 32'hDEAD);
      end else begin
        b = exp_q.pop_front();
        chk("beat", 32'({m_data, m_user, m_last}), 32'(b));
      end
    end
    err_exp = 0;
    fwd_prev = 0;
    if (s_valid && s_ready) model_in(s_data, s_user);
    stall_prev = m_valid && !m_ready;
    stall_beat = beat_t'({m_data, m_user, m_last});
    rst_prev = rst;
    if (rst) begin
      exp_q.delete();
      in_frame = 0; pos = 0; dropping = 0;
      err_exp = 0; fwd_prev = 0; stall_prev = 0;
    end
  end

  // ---------------- drivers
  task automatic send(input logic [DW-1:0] d, input logic u, input int gap);
    logic acc;
    for (int g = 0; g < gap; g++) begin
      s_valid = 1'b0;
      @(negedge clk);
    end
    s_valid = 1'b1; s_data = d; s_user = u; s_last = 1'($urandom);
    for (int t = 0; ; t++) begin
      #4 acc = s_ready;
      @(negedge clk);
      if (acc) break;
      if (t > 20000) begin
        chk("send_timeout", 32'(t), 32'd0);
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic send_run(input int cnt, input logic sof, input bit gaps);
    for (int i = 0; i < cnt; i++)
      send(DW'($urandom), sof && (i == 0),
           (gaps && $urandom_range(7) == 0) ? 1 : 0);
  endtask

  task automatic drain();
    mode = 0;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- 4x2 cycle table
  typedef struct packed {
    logic v, u; logic [7:0] d; logic mr;
    logic mv; logic [7:0] ed; logic eu, el, eerr, esr;
  } vec_t;

  vec_t tv[20];

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint t0;
    tv = '{
      '{1,0,8'h10,1, 0,8'h00,0,0,0,1}, '{1,0,8'h11,1, 0,8'h00,0,0,1,1},
      '{1,1,8'h20,1, 0,8'h00,0,0,0,1}, '{1,0,8'h21,1, 1,8'h20,1,0,0,1},
      '{1,0,8'h22,1, 1,8'h21,0,0,0,1}, '{1,0,8'h23,1, 1,8'h22,0,0,0,1},
      '{1,0,8'h24,1, 1,8'h23,0,0,0,1}, '{1,0,8'h25,1, 1,8'h24,0,0,0,1},
      '{1,0,8'h26,1, 1,8'h25,0,0,0,1}, '{1,1,8'h30,1, 1,8'h26,0,0,0,1},
      '{1,0,8'h31,1, 0,8'h00,0,0,1,0}, '{1,0,8'h31,1, 1,8'h00,0,1,0,0},
      '{1,0,8'h31,1, 1,8'h30,1,0,0,1}, '{0,0,8'h00,1, 1,8'h31,0,0,0,1},
      '{0,0,8'h00,1, 0,8'h00,0,0,0,1}, '{1,0,8'h32,0, 0,8'h00,0,0,0,1},
      '{1,0,8'h33,0, 1,8'h32,0,0,0,0}, '{1,0,8'h33,1, 1,8'h32,0,0,0,1},
      '{0,0,8'h00,1, 1,8'h33,0,0,0,1}, '{0,0,8'h00,1, 0,8'h00,0,0,0,1}
    };
    rst = 1'b1; m_ready = 1'b1; mode = 0;
    s_valid = 0; s_user = 0; s_last = 0; s_data = '0;
    t_svalid = 0; t_suser = 0; t_slast = 1; t_sdata = '0; t_mready = 1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      t_svalid = tv[i].v; t_suser = tv[i].u;
      t_sdata = DW'(tv[i].d); t_mready = tv[i].mr;
      #4;
      chk($sformatf("tiny_ctl[%0d]", i),
          32'({t_mvalid, t_err, t_sready}),
          32'({tv[i].mv, tv[i].eerr, tv[i].esr}));
      if (tv[i].mv)
        chk($sformatf("tiny_beat[%0d]", i),
            32'({t_mdata, t_muser, t_mlast}),
            32'({DW'(tv[i].ed), tv[i].eu, tv[i].el}));
      @(negedge clk);
    end
    t_svalid = 0;
`ifdef AXIS_FRAME_ALIGNER_STATS_EN
    chk("tiny_stats", 32'({tst_frames[3:0], tst_padded[3:0], tst_dropped[3:0]}),
        32'h112);
`endif

    // clean frame, full throughput
    mode = 0; err_pulses = 0;
    t0 = $time;
    send_run(N, 1, 0);
    chk("throughput", 32'(($time - t0) / 10), 32'(N));
    drain();
    chk("clean_err", 32'(err_pulses), 32'd0);

    // same frame, output ready toggling every cycle
    mode = 1;
    send_run(N, 1, 0);
    drain();

    // 50 stray pixels then a clean frame with random input gaps
    err_pulses = 0;
    send_run(50, 0, 1);
    send_run(N, 1, 1);
    drain();
    chk("drop_pulses", 32'(err_pulses), 32'd1);
`ifdef AXIS_FRAME_ALIGNER_STATS_EN
    chk("stat_dropped", 32'(st_dropped), 32'd50);
`endif

    // frame truncated at pixel 5000 by a new SOF
    err_pulses = 0;
    send_run(5000, 1, 0);
    send(DW'(24'hABCDEF), 1'b1, 0);
    send_run(10, 0, 0);
    drain();
    chk("pad_pulses", 32'(err_pulses), 32'd1);
`ifdef AXIS_FRAME_ALIGNER_STATS_EN
    chk("stat_padded", 32'(st_padded), 32'd1);
`endif

    // reset mid-frame under random backpressure, then a clean frame
    mode = 2;
    send_run(3000, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mode = 0; err_pulses = 0;
    send_run(N, 1, 0);
    drain();
    chk("post_rst_err", 32'(err_pulses), 32'd0);
`ifdef AXIS_FRAME_ALIGNER_STATS_EN
    chk("stats_after_rst", 32'({st_frames, st_padded[7:0], st_dropped[7:0]}),
        32'h0001_0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axis_frame_aligner.md
# axis_frame_aligner

Upstream conditioning stage for `barrel_distortion_correction`.
- Accepts an AXI4-Stream pixel stream from the video source.
- Locks onto start-of-frame and regenerates `tuser`/`tlast` on exact WIDTH×HEIGHT boundaries.
- Pads truncated frames with zero pixels and drops stray pixels, so the corrector always receives well-formed frames.

## Interface
- `WIDTH`, 128, active pixels per line
- `HEIGHT`, 100, lines per frame
- `DATA_WIDTH`, 24, pixel width (RGB888)
- `PAD_VALUE`, 0, pixel value inserted when padding (DATA_WIDTH bits)

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  synchronous reset, active-high
- `s_axis_tdata`  in  DATA_WIDTH  input pixel
- `s_axis_tvalid`  in  1  input valid
- `s_axis_tuser`  in  1  start of frame
- `s_axis_tlast`  in  1  ignored; boundaries are regenerated
- `s_axis_tready`  out  1  input ready
- `m_axis_tdata`  out  DATA_WIDTH  output pixel
- `m_axis_tvalid`  out  1  output valid
- `m_axis_tuser`  out  1  first pixel of frame
- `m_axis_tlast`  out  1  last pixel of frame (x=WIDTH-1, y=HEIGHT-1)
- `m_axis_tready`  in  1  output ready
- `frame_err`  out  1  one-cycle pulse on a pad or drop event

## Operation
- Counters: `x` (0..WIDTH-1) and `y` (0..HEIGHT-1) count output beats.
- `x` wraps to 0 and `y` increments when `x`=WIDTH-1.
- Both counters clear after the tlast beat.

States:
- `WAIT_SOF`
  - `s_axis_tready`=1.
  - Beats without tuser are discarded; `frame_err` pulses once per contiguous drop run.
  - A tuser beat is forwarded with `m_axis_tuser`=1, then the state moves to `ACTIVE`.
- `ACTIVE`
  - Beats are forwarded.
  - The beat that completes the frame carries `m_axis_tlast`=1, then the state moves to `WAIT_SOF`.
  - A tuser beat arriving before frame end is captured into `hold_reg` (accepted), `frame_err` pulses, and the state moves to `PAD`.
- `PAD`
  - `s_axis_tready`=0.
  - PAD_VALUE beats are emitted until the frame completes; the last one carries tlast.
  - The state then moves to `RELEASE`.
- `RELEASE`
  - `s_axis_tready`=0.
  - `hold_reg` is emitted with `m_axis_tuser`=1, `x`=1 next.
  - The state then moves to `ACTIVE`.
- A tuser beat that coincides with the final pixel slot of `ACTIVE` is treated as early: the frame is padded by 1 beat.
- HEIGHT=1, WIDTH=1 is legal: every beat carries both tuser and tlast.

## Timing
- The output is a single register stage: latency 1 cycle from input handshake to `m_axis_tvalid`.
- In `WAIT_SOF`/`ACTIVE`, `s_axis_tready` = !`m_axis_tvalid` || `m_axis_tready`. This is combinational, and full throughput is 1 beat/cycle.
- `m_axis_tvalid`, tdata, tuser and tlast hold stable while `m_axis_tvalid`=1 and `m_axis_tready`=0.
- PAD/RELEASE beats advance only on output handshake.
- Reset values:
  - all `m_axis_*`=0
  - `s_axis_tready`=0 during reset, then 1 on the first cycle after
  - `frame_err`=0
  - state=`WAIT_SOF`
  - x=y=0
- Reset mid-frame aborts immediately. The partial frame is not completed, and `hold_reg` is discarded.
- `frame_err` is registered and asserts the cycle after the offending input handshake.

## Configuration
- `AXIS_FRAME_ALIGNER_STATS_EN` defined: adds three output ports.
  - `stat_frames` [15:0]: frames completed
  - `stat_padded` [15:0]: padded frames
  - `stat_dropped` [15:0]: dropped pixels
  - All three saturate at 16'hFFFF and clear on `rst`.
- Undefined: these ports and counters do not exist, and there is no other behaviour change.

## Structure
- Package `frame_aligner_pkg`:
  - state enum (`WAIT_SOF`, `ACTIVE`, `PAD`, `RELEASE`)
  - `X_W`=$clog2(WIDTH) and `Y_W`=$clog2(HEIGHT) helper functions
  - stats width constant (16)
- Sub-module `axis_out_reg`: the 1-deep output register slice (data+user+last, valid/ready). Reused by other stages.

## Test plan
- Clean 128×100 frame, `m_axis_tready`=1:
  - 12800 beats out, data identical.
  - tuser on beat 0 only; tlast on beat 12799 only.
  - latency 1 cycle; `frame_err` never asserts.
- Same frame with `m_axis_tready` toggling 1-0 every cycle:
  - no loss or duplication.
  - output stable while stalled.
  - `s_axis_tready` low whenever the output is full and not ready.
- 50 pixels without tuser, then a clean frame:
  - 50 dropped; one `frame_err` pulse.
  - output frame starts at the first tuser pixel.
  - `stat_dropped`=50 with stats enabled.
- Frame truncated at pixel 5000 by a new tuser:
  - 7800 PAD_VALUE beats, the last with tlast.
  - then the held pixel with tuser.
  - `frame_err`=1 once; `stat_padded`=1.
- `rst` asserted at pixel 3000:
  - the next cycle shows all outputs at 0.
  - after release, the next tuser frame passes cleanly with x,y starting at 0.
- WIDTH=4, HEIGHT=2 build, tuser on the 8th pixel slot: 1 pad beat, then the new frame.
